// File: rtl/udp_rx_payload_reader_pkg.sv
// udp_rx_payload_reader_pkg: shared FSM encodings, beat type and payload-length helper
package udp_rx_payload_reader_pkg;
    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_LOAD  = 5'b00010;
    localparam logic [4:0] ST_READ  = 5'b00100;
    localparam logic [4:0] ST_DRAIN = 5'b01000;
    localparam logic [4:0] ST_DONE  = 5'b10000;
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;
    // UDP length minus header, floored at zero without wrapping
    function automatic logic [16:0] payload_len(input logic [15:0] len, input logic [15:0] hdr);
        return (len > hdr) ? 17'(len) - 17'(hdr) : 17'd0;
    endfunction
endpackage

// File: rtl/udp_rx_payload_reader_if.sv
// udp_rx_payload_reader_if: payload byte stream with valid/ready and last marker
//   data/valid/last driven by master, ready driven by slave
interface udp_rx_payload_reader_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       last;
    modport master(output data, valid, last, input ready);
    modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/udp_rx_payload_reader_skid_fifo.sv
// udp_rx_payload_reader_skid_fifo: 2-entry {last,data} buffer, head is the output entry
//   push/din write, pop drops head, occ = entries held (0..2); caller guarantees no overflow
module udp_rx_payload_reader_skid_fifo
    import udp_rx_payload_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  beat_t      din,
    output beat_t      head,
    output logic [1:0] occ
);
    beat_t tail;
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            head <= pop ? ((push && occ == 2'd1) ? din : tail) : ((push && occ == 2'd0) ? din : head);
            tail <= (push && (pop ? occ == 2'd2 : occ == 2'd1)) ? din : tail;
            occ  <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/udp_rx_payload_reader.sv
// udp_rx_payload_reader: drains the UDP receive RAM into a byte stream after each good packet
//   udp_rec_data_valid/length in, RAM read addr out / rdata in, stream m (master),
//   busy, pkt_done pulse, sticky len_err, saturating overrun_cnt
module udp_rx_payload_reader
    import udp_rx_payload_reader_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int HDR_LEN = 8,
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  udp_rec_data_valid,
    input  logic [15:0]           udp_rec_data_length,
    output logic [ADDR_W-1:0]     udp_rec_ram_read_addr,
    input  logic [7:0]            udp_rec_ram_rdata,
    udp_rx_payload_reader_if.master m,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  len_err,
    output logic [7:0]            overrun_cnt
);
    localparam int PW = ADDR_W + 1;
    localparam logic [16:0] MAXLEN = 17'(2 ** ADDR_W);
    logic [4:0]         st;
    logic               valid_d;
    logic [PW-1:0]      plen_r, issued, plen_c;
    logic [ADDR_W-1:0]  rd_addr;
    logic [RAM_LAT-1:0] v, l;
    logic [1:0]         occ, infl;
    logic [16:0]        plen_raw;
    logic               rise, issue, pop, last_rd;
    beat_t              head;
    assign rise     = udp_rec_data_valid & ~valid_d;
    assign plen_raw = payload_len(udp_rec_data_length, 16'(HDR_LEN));
    assign plen_c   = (plen_raw > MAXLEN) ? PW'(MAXLEN) : PW'(plen_raw);
    assign pop      = m.valid & m.ready;
    assign infl     = 2'($countones(v));
    assign last_rd  = issued == plen_r - PW'(1);
    // credit: buffered + in-flight bytes, less the one leaving now, must leave room for another
    assign issue    = st == ST_READ && issued != plen_r && 3'(occ) + 3'(infl) < 3'(pop) + 3'd2;
    assign udp_rec_ram_read_addr = rd_addr;
    assign m.valid  = occ != 2'd0;
    assign m.data   = head.data;
    assign m.last   = head.last;
    assign busy     = st != ST_IDLE;
    assign pkt_done = st == ST_DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            valid_d     <= 1'b0;
            plen_r      <= '0;
            issued      <= '0;
            rd_addr     <= '0;
            v           <= '0;
            l           <= '0;
            len_err     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            valid_d <= udp_rec_data_valid;
            // read-latency pipeline carrying the valid and last tags alongside the RAM
            v <= RAM_LAT'({v, issue});
            l <= RAM_LAT'({l, issue & last_rd});
            if (rise && st != ST_IDLE && overrun_cnt != 8'hff)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (issue) begin
                issued <= issued + PW'(1);
                // hold on the final address so a full-depth packet never wraps
                if (!last_rd)
                    rd_addr <= rd_addr + ADDR_W'(1);
            end
            case (st)
                ST_IDLE:  if (rise) st <= ST_LOAD;
                ST_LOAD: begin
                    plen_r  <= plen_c;
                    issued  <= '0;
                    rd_addr <= '0;
                    len_err <= len_err | (plen_raw > MAXLEN);
                    st      <= (plen_c == '0) ? ST_DONE : ST_READ;
                end
                ST_READ:  if (issue && last_rd) st <= ST_DRAIN;
                // only the final beat can remain once nothing is in flight
                ST_DRAIN: if (infl == 2'd0 && occ == 2'd1 && pop) st <= ST_DONE;
                default:  st <= ST_IDLE;
            endcase
        end
    end
    udp_rx_payload_reader_skid_fifo u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (v[RAM_LAT-1]),
        .pop  (pop),
        .din  ({l[RAM_LAT-1], udp_rec_ram_rdata}),
        .head (head),
        .occ  (occ)
    );
endmodule
